// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle between the command-driven master and its slave.
interface axi4_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AW+W+B or AR+R
// transaction on the bus, one response out, with a non-aborting stall watchdog.
module axi4_lite_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_write,
  output logic                timeout,
  axi4_lite_master_if.master  axi
);
  localparam int STRB_W = DATA_W / 8;
  localparam int WD_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1'b1);
  localparam logic            WD_EN  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                write_q, write_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic                timeout_q, timeout_d;

  logic aw_hs_s;
  logic w_hs_s;
  logic bus_phase_s;

  assign aw_hs_s     = awvalid_q & axi.awready;
  assign w_hs_s      = wvalid_q & axi.wready;
  assign bus_phase_s = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                       (state_q == RD_REQ) || (state_q == RD_DATA);

  // Next-state and next-output computation for the transaction FSM and watchdog.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    write_d     = write_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    wd_cnt_d    = wd_cnt_q;
    timeout_d   = timeout_q;

    // Watchdog only observes; VALIDs are never withdrawn on expiry.
    if (bus_phase_s && WD_EN) begin
      if (wd_cnt_q != WD_MAX) begin
        wd_cnt_d = wd_cnt_q + WD_ONE;
      end else begin
        wd_cnt_d = wd_cnt_q;
      end
      timeout_d = timeout_q | (wd_cnt_d == WD_MAX);
    end else begin
      wd_cnt_d  = wd_cnt_q;
      timeout_d = timeout_q;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          write_d     = cmd_write;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          wd_cnt_d    = WD_ONE;
          timeout_d   = 1'b0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | aw_hs_s;
        w_done_d  = w_done_q | w_hs_s;
        if (aw_hs_s) begin
          awvalid_d = 1'b0;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (w_hs_s) begin
          wvalid_d = 1'b0;
        end else begin
          wvalid_d = wvalid_q;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end else begin
          state_d = state_q;
        end
      end
      WR_RESP: begin
        if (axi.bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_resp_d  = axi.bresp;
          rsp_rdata_d = {DATA_W{1'b0}};
          rsp_valid_d = 1'b1;
          timeout_d   = timeout_q;
          state_d     = RSP;
        end else begin
          state_d = state_q;
        end
      end
      RD_REQ: begin
        if (arvalid_q && axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end else begin
          state_d = state_q;
        end
      end
      RD_DATA: begin
        if (axi.rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_resp_d  = axi.rresp;
          rsp_rdata_d = axi.rdata;
          rsp_valid_d = 1'b1;
          timeout_d   = timeout_q;
          state_d     = RSP;
        end else begin
          state_d = state_q;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          timeout_d   = 1'b0;
          wd_cnt_d    = {WD_W{1'b0}};
          state_d     = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
        timeout_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; asynchronous reset drops every VALID at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      wstrb_q     <= {STRB_W{1'b0}};
      write_q     <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_resp_q  <= 2'b00;
      wd_cnt_q    <= {WD_W{1'b0}};
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      write_q     <= write_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_write   = write_q;
  assign timeout     = timeout_q;

  assign axi.awaddr  = addr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.araddr  = addr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master: slave behaviour scripted step by step,
// expected responses queued at command time and compared when rsp_valid appears.
module tb_axi4_lite_master;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        write;
  } rsp_t;

  rsp_t exp_q[$];

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_write;
  logic        timeout;

  int errors = 0;
  int checks = 0;
  int aw_cnt = 0;
  int w_cnt  = 0;
  int b_cnt  = 0;
  int ar_cnt = 0;
  int r_cnt  = 0;

  axi4_lite_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi4_lite_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write), .timeout(timeout),
    .axi(bus)
  );

  always #5 clk = ~clk;

  // Handshake counters sampled on the active edge.
  always @(posedge clk) begin
    if (bus.awvalid && bus.awready) aw_cnt <= aw_cnt + 1;
    if (bus.wvalid && bus.wready)   w_cnt  <= w_cnt + 1;
    if (bus.bvalid && bus.bready)   b_cnt  <= b_cnt + 1;
    if (bus.arvalid && bus.arready) ar_cnt <= ar_cnt + 1;
    if (bus.rvalid && bus.rready)   r_cnt  <= r_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL tb_time_limit: observed=still running expected=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [1:0] r, input logic w);
    rsp_t e;
    e.rdata = d;
    e.resp  = r;
    e.write = w;
    exp_q.push_back(e);
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    rsp_t e;
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_sb_nonempty"}, (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_resp"},  rsp_resp,  e.resp);
      check({tag, "_write"}, rsp_write, e.write);
    end
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_rsp_gone"}, rsp_valid, 0);
    check({tag, "_cmd_ready_back"}, cmd_ready, 1);
  endtask

  initial begin
    int a0, w0, b0, ar0, r0;
    resetn    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0;
    rsp_ready = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bresp = 2'b00; bus.bvalid = 1'b0;
    bus.arready = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00; bus.rvalid = 1'b0;

    // Reset state
    #2 resetn = 1'b0;
    tick();
    tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp", {rsp_valid, rsp_resp, rsp_write, timeout}, 5'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_bus_ctl", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'b0);
    check("rst_addr", {bus.awaddr, bus.wdata}, 64'h0);
    resetn = 1'b1;
    tick();
    check("post_rst_cmd_ready", cmd_ready, 1);

    // T1: write 0x2 to 0x0, AW and W ready together, B one cycle later
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    bus.awready = 1'b1; bus.wready = 1'b1;
    push_exp(32'h0, 2'b00, 1'b1);
    send_cmd(1'b1, 32'h0, 32'h0000_0002, 4'hF);
    check("t1_valid_latency", {bus.awvalid, bus.wvalid, bus.arvalid}, 3'b110);
    check("t1_cmd_ready_low", cmd_ready, 0);
    check("t1_awaddr", bus.awaddr, 32'h0);
    check("t1_wdata", bus.wdata, 32'h0000_0002);
    tick();
    check("t1_after_hs", {bus.awvalid, bus.wvalid, bus.bready}, 3'b001);
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b1; bus.bresp = 2'b00;
    tick();
    bus.bvalid = 1'b0;
    wait_rsp("t1");
    check("t1_hs_counts", {8'(aw_cnt - a0), 8'(w_cnt - w0), 8'(b_cnt - b0)}, 24'h010101);
    check("t1_no_timeout", timeout, 0);
    consume("t1");

    // T2: WREADY three cycles after AWREADY
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    bus.awready = 1'b1; bus.wready = 1'b0;
    push_exp(32'h0, 2'b00, 1'b1);
    send_cmd(1'b1, 32'h4, 32'hDEAD_BEEF, 4'b0101);
    check("t2_wstrb", bus.wstrb, 4'b0101);
    tick();
    bus.awready = 1'b0;
    check("t2_aw_dropped", {bus.awvalid, bus.wvalid, bus.bready}, 3'b010);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t2_w_held", {bus.awvalid, bus.wvalid, bus.wdata}, {2'b01, 32'hDEAD_BEEF});
    end
    bus.wready = 1'b1;
    tick();
    bus.wready = 1'b0;
    check("t2_w_dropped", {bus.wvalid, bus.bready}, 2'b01);
    bus.bvalid = 1'b1; bus.bresp = 2'b00;
    tick();
    bus.bvalid = 1'b0;
    tick();
    tick();
    wait_rsp("t2");
    check("t2_hs_counts", {8'(aw_cnt - a0), 8'(w_cnt - w0), 8'(b_cnt - b0)}, 24'h010101);
    consume("t2");

    // T3: read 0x0, ARREADY after two cycles, RDATA=9
    ar0 = ar_cnt; r0 = r_cnt;
    push_exp(32'h0000_0009, 2'b00, 1'b0);
    send_cmd(1'b0, 32'h0, 32'h0, 4'h0);
    check("t3_arvalid_1", {bus.arvalid, bus.awvalid, bus.wvalid}, 3'b100);
    check("t3_araddr", bus.araddr, 32'h0);
    tick();
    check("t3_arvalid_2", bus.arvalid, 1);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    check("t3_ar_dropped", {bus.arvalid, bus.rready}, 2'b01);
    bus.rvalid = 1'b1; bus.rdata = 32'h0000_0009; bus.rresp = 2'b00;
    tick();
    bus.rvalid = 1'b0; bus.rdata = 32'h0;
    wait_rsp("t3");
    check("t3_hs_counts", {8'(ar_cnt - ar0), 8'(r_cnt - r0)}, 16'h0101);
    consume("t3");

    // T4: response held 5 cycles with a new command pending
    bus.arready = 1'b1;
    push_exp(32'hA5A5_0001, 2'b11, 1'b0);
    send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
    check("t4_araddr", bus.araddr, 32'h10);
    tick();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'hA5A5_0001; bus.rresp = 2'b11;
    tick();
    bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0;
    cmd_wdata = 32'h0000_0001; cmd_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      check("t4_cmd_ready_low", cmd_ready, 0);
      check("t4_rsp_stable", {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, 2'b11, 32'hA5A5_0001});
      tick();
    end
    wait_rsp("t4r");
    push_exp(32'h0, 2'b01, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t4_idle_cmd_ready", {cmd_ready, bus.awvalid, rsp_valid}, 3'b100);
    bus.awready = 1'b1; bus.wready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("t4_accepted", {cmd_ready, bus.awvalid, bus.wvalid}, 3'b011);
    tick();
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b1; bus.bresp = 2'b01;
    tick();
    bus.bvalid = 1'b0;
    wait_rsp("t4w");
    consume("t4w");

    // T5: B withheld 20 bus cycles, watchdog at 8, late SLVERR
    bus.awready = 1'b1; bus.wready = 1'b1;
    push_exp(32'h0, 2'b10, 1'b1);
    send_cmd(1'b1, 32'h4, 32'h0000_0001, 4'h1);
    for (int k = 1; k <= 20; k++) begin
      check("t5_timeout", timeout, (k >= TMO) ? 1 : 0);
      if (k == 2) begin
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
      end
      tick();
    end
    check("t5_still_waiting", {bus.bready, rsp_valid}, 2'b10);
    bus.bvalid = 1'b1; bus.bresp = 2'b10;
    tick();
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    check("t5_timeout_in_rsp", timeout, 1);
    wait_rsp("t5");
    consume("t5");
    check("t5_timeout_cleared", timeout, 0);

    // T6: reset asserted during WR_REQ
    send_cmd(1'b1, 32'h8, 32'h0000_0003, 4'hF);
    check("t6_valid_before", {bus.awvalid, bus.wvalid}, 2'b11);
    #2 resetn = 1'b0;
    #1;
    check("t6_async_drop", {bus.awvalid, bus.wvalid}, 2'b00);
    tick();
    resetn = 1'b1;
    tick();
    check("t6_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      check("t6_no_rsp", {rsp_valid, bus.awvalid, bus.wvalid}, 3'b000);
      tick();
    end
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
